// File: rtl/superscalar_free_list.sv
// Multi-lane physical-register free list: circular FIFO of free PRs with checkpoint rollback.
// Define FL_RETIRE_BYPASS_EN to let same-cycle retires satisfy allocations directly.
module superscalar_free_list #(
  parameter int NUM_PR  = 64,
  parameter int NUM_FL  = 32,
  parameter int WAYS    = 2,
  parameter int ZERO_PR = 31,
  localparam int PRW    = $clog2(NUM_PR),
  localparam int PTRW   = $clog2(NUM_FL)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [WAYS-1:0]           i_dispatch_req,
  input  logic                      i_rollback_en,
  input  logic [PTRW:0]             i_rollback_ptr,
  input  logic [WAYS-1:0]           i_retire_valid,
  input  logic [WAYS-1:0][PRW-1:0]  i_retire_told,
  output logic [WAYS-1:0][PRW-1:0]  o_alloc_pr,
  output logic [PTRW:0]             o_alloc_ptr,
  output logic                      o_dispatch_gnt,
  output logic [PTRW:0]             o_free_count
);
  localparam int CW = PTRW + 1;

  logic [PRW-1:0]  r_table [NUM_FL];
  logic [CW-1:0]   r_head;
  logic [CW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [WAYS-1:0] w_ret_qual;
  logic [CW-1:0]   w_req_off [WAYS];
  logic [CW-1:0]   w_ret_off [WAYS];
  logic [CW-1:0]   w_req_cnt;
  logic [CW-1:0]   w_ret_cnt;
  logic [CW:0]     w_avail;
  logic            w_gnt;
  logic [CW-1:0]   w_head_next;
  logic [CW-1:0]   w_tail_next;
  logic [PTRW-1:0] w_wr_idx [WAYS];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_qual
    assign w_ret_qual[gi] = i_retire_valid[gi] && (i_retire_told[gi] != PRW'(ZERO_PR));
  end

  // Exclusive prefix counts give each lane its compacted slot.
  always_comb begin
    w_req_cnt = '0;
    w_ret_cnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_req_off[i] = w_req_cnt;
      w_ret_off[i] = w_ret_cnt;
      w_req_cnt    = w_req_cnt + CW'(i_dispatch_req[i]);
      w_ret_cnt    = w_ret_cnt + CW'(w_ret_qual[i]);
    end
  end

`ifdef FL_RETIRE_BYPASS_EN
  localparam int IW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0][PRW-1:0] w_ret_comp;

  always_comb begin
    w_ret_comp = {WAYS{PRW'(ZERO_PR)}};
    for (int i = 0; i < WAYS; i++) begin
      if (w_ret_qual[i]) w_ret_comp[IW'(w_ret_off[i])] = i_retire_told[i];
    end
  end

  assign w_avail = {1'b0, r_count} + (i_rollback_en ? {(CW+1){1'b0}} : {1'b0, w_ret_cnt});
`else
  assign w_avail = {1'b0, r_count};
`endif

  assign w_gnt = !i_rollback_en && ({1'b0, w_req_cnt} <= w_avail);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
    logic [PTRW-1:0] w_rd_idx;
    assign w_rd_idx     = PTRW'(r_head + w_req_off[gi]);
    assign w_wr_idx[gi] = PTRW'(r_tail + w_ret_off[gi]);
`ifdef FL_RETIRE_BYPASS_EN
    // Slots beyond the stored entries come straight from this cycle's retires.
    logic [IW-1:0] w_byp_sel;
    logic          w_byp_use;
    assign w_byp_sel = IW'(w_req_off[gi] - r_count);
    assign w_byp_use = !i_rollback_en && (w_req_off[gi] >= r_count);
    assign o_alloc_pr[gi] = !i_dispatch_req[gi] ? PRW'(ZERO_PR) :
                            w_byp_use           ? w_ret_comp[w_byp_sel] :
                                                  r_table[w_rd_idx];
`else
    assign o_alloc_pr[gi] = i_dispatch_req[gi] ? r_table[w_rd_idx] : PRW'(ZERO_PR);
`endif
  end

  always_comb begin
    w_head_next = r_head;
    if (i_rollback_en)  w_head_next = i_rollback_ptr;
    else if (w_gnt)     w_head_next = r_head + w_req_cnt;
  end

  assign w_tail_next    = r_tail + w_ret_cnt;
  assign o_alloc_ptr    = w_head_next;
  assign o_dispatch_gnt = w_gnt;
  assign o_free_count   = r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= CW'(NUM_FL);
      r_count <= CW'(NUM_FL);
      for (int i = 0; i < NUM_FL; i++) r_table[i] <= PRW'(NUM_PR - NUM_FL + i);
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_tail_next - w_head_next;
      for (int i = 0; i < WAYS; i++) begin
        if (w_ret_qual[i]) r_table[w_wr_idx[i]] <= i_retire_told[i];
      end
    end
  end
endmodule
